// File: rtl/fp_unit_sequencer.sv
// fp_unit_sequencer: in-order FP issue queue feeding a multi-cycle datapath, with a writeback-slot
// reservation map and tag pipeline; optional perf counters are enabled by FP_SEQ_PERF_EN.
module fp_unit_sequencer #(
    parameter int QUEUE_DEPTH = 4,
    parameter int TICKET_BITS = 3,
    parameter int DEST_BITS   = 6,
    parameter int DATA_BITS   = 32,
    parameter int ADD_LAT     = 3,
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   valid,
    input  logic [TICKET_BITS-1:0] in_ticket,
    input  logic [DEST_BITS-1:0]   in_dest,
    input  logic [1:0]             in_opclass,
    output logic                   busy_fu,
    output logic                   dp_start,
    output logic [1:0]             dp_opclass,
    input  logic [DATA_BITS-1:0]   dp_result_data,
    input  logic                   dp_result_exc,
    input  logic [4:0]             dp_result_cause,
    output logic                   fu_valid,
    output logic [DEST_BITS-1:0]   fu_destination,
    output logic [TICKET_BITS-1:0] fu_ticket,
    output logic [DATA_BITS-1:0]   fu_data,
    output logic                   fu_valid_exception,
    output logic [4:0]             fu_cause
`ifdef FP_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_disp_cnt
`endif
);

    localparam int MAX_LAT = DIV_LAT;
    localparam int LB = $clog2(MAX_LAT + 1);
    localparam int PB = $clog2(QUEUE_DEPTH);
    localparam bit [PB:0] FULL = QUEUE_DEPTH[PB:0];

    logic [TICKET_BITS-1:0] q_ticket [QUEUE_DEPTH];
    logic [DEST_BITS-1:0]   q_dest [QUEUE_DEPTH];
    logic [1:0]             q_class [QUEUE_DEPTH];
    logic [PB-1:0]          head, tail;
    logic [PB:0]            count;
    logic [MAX_LAT:1]       res, res_shift, res_next;
    logic [TICKET_BITS-1:0] p_ticket [1:MAX_LAT];
    logic [DEST_BITS-1:0]   p_dest [1:MAX_LAT];
    logic [LB-1:0]          div_cnt, div_next, lat;
    logic [1:0]             head_class;
    logic                   enq, disp;

    always_comb begin
        head_class = q_class[head];
        lat = head_class == 2'd0 ? LB'(ADD_LAT) :
              head_class == 2'd1 ? LB'(MUL_LAT) :
              head_class == 2'd2 ? LB'(DIV_LAT) : LB'(1);
        res_shift = res >> 1;
        // divider is free if it would reach zero by the end of this cycle
        div_next = div_cnt - LB'(div_cnt != '0);
        busy_fu = count == FULL;
        enq = valid && !busy_fu && !flush;
        disp = !flush && count != '0 && !res_shift[lat] && (head_class != 2'd2 || div_next == '0);
        res_next = res_shift;
        if (disp) res_next[lat] = 1'b1;
        dp_start = disp;
        dp_opclass = disp ? head_class : 2'd0;
        fu_valid = res[1];
        fu_ticket = res[1] ? p_ticket[1] : '0;
        fu_destination = res[1] ? p_dest[1] : '0;
        fu_data = res[1] ? dp_result_data : '0;
        fu_valid_exception = res[1] && dp_result_exc;
        fu_cause = res[1] ? dp_result_cause : 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            res <= '0;
            div_cnt <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            res <= '0;
            div_cnt <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (disp) head <= head + 1'b1;
            count <= count + (PB+1)'(enq) - (PB+1)'(disp);
            res <= res_next;
            div_cnt <= (disp && head_class == 2'd2) ? LB'(DIV_LAT) : div_next;
        end
    end

    // payload storage needs no reset: every read is qualified by count or the reservation map
    always_ff @(posedge clk) begin
        if (enq) begin
            q_ticket[tail] <= in_ticket;
            q_dest[tail] <= in_dest;
            q_class[tail] <= in_opclass;
        end
        for (int i = 1; i < MAX_LAT; i++) begin
            p_ticket[i] <= p_ticket[i+1];
            p_dest[i] <= p_dest[i+1];
        end
        if (disp) begin
            p_ticket[lat] <= q_ticket[head];
            p_dest[lat] <= q_dest[head];
        end
    end

`ifdef FP_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_disp_cnt <= '0;
        end else begin
            if (count != '0 && !disp && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (disp && perf_disp_cnt != '1) perf_disp_cnt <= perf_disp_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_unit_sequencer.sv
// tb_fp_unit_sequencer: directed self-checking bench for fp_unit_sequencer (default build).
module tb_fp_unit_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  in_ticket = '0;
    logic [5:0]  in_dest = '0;
    logic [1:0]  in_opclass = '0;
    logic [31:0] dp_result_data = '0;
    logic        dp_result_exc = 1'b0;
    logic [4:0]  dp_result_cause = '0;
    logic        busy_fu, dp_start, fu_valid, fu_valid_exception;
    logic [1:0]  dp_opclass;
    logic [5:0]  fu_destination;
    logic [2:0]  fu_ticket;
    logic [31:0] fu_data;
    logic [4:0]  fu_cause;
    int checks = 0;
    int passed = 0;
    int fails = 0;
    int n_disp;
    logic [2:0] last_ticket;
    logic bad;

    fp_unit_sequencer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .valid(valid),
        .in_ticket(in_ticket), .in_dest(in_dest), .in_opclass(in_opclass),
        .busy_fu(busy_fu), .dp_start(dp_start), .dp_opclass(dp_opclass),
        .dp_result_data(dp_result_data), .dp_result_exc(dp_result_exc), .dp_result_cause(dp_result_cause),
        .fu_valid(fu_valid), .fu_destination(fu_destination), .fu_ticket(fu_ticket),
        .fu_data(fu_data), .fu_valid_exception(fu_valid_exception), .fu_cause(fu_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] t, input logic [5:0] d, input logic [1:0] c);
        valid = 1'b1;
        in_ticket = t;
        in_dest = d;
        in_opclass = c;
    endtask

    task automatic idle();
        valid = 1'b0;
    endtask

    initial begin
        // reset values
        #1;
        chk("rst_busy", 64'(busy_fu), 64'(0));
        chk("rst_start", 64'(dp_start), 64'(0));
        chk("rst_fu_valid", 64'(fu_valid), 64'(0));
        chk("rst_opclass", 64'(dp_opclass), 64'(0));
        chk("rst_fu_ticket", 64'(fu_ticket), 64'(0));
        cycle();
        rst_n = 1'b1;
        cycle();

        // single add: dp_start at +1, writeback at +4
        issue(3'd2, 6'd10, 2'd0);
        @(negedge clk); chk("t1_no_same_cycle", 64'(dp_start), 64'(0));
        cycle(); idle();
        @(negedge clk); chk("t1_start", 64'(dp_start), 64'(1)); chk("t1_class", 64'(dp_opclass), 64'(0));
        cycle(); cycle();
        @(negedge clk); chk("t1_early", 64'(fu_valid), 64'(0));
        cycle();
        dp_result_data = 32'hDEADBEEF; dp_result_exc = 1'b1; dp_result_cause = 5'h11;
        @(negedge clk);
        chk("t1_valid", 64'(fu_valid), 64'(1));
        chk("t1_ticket", 64'(fu_ticket), 64'(2));
        chk("t1_dest", 64'(fu_destination), 64'(10));
        chk("t1_data", 64'(fu_data), 64'h0DEADBEEF);
        chk("t1_exc", 64'(fu_valid_exception), 64'(1));
        chk("t1_cause", 64'(fu_cause), 64'h11);
        cycle();
        @(negedge clk);
        chk("t1_after_valid", 64'(fu_valid), 64'(0));
        chk("t1_after_data", 64'(fu_data), 64'(0));
        chk("t1_after_cause", 64'(fu_cause), 64'(0));
        dp_result_data = 32'h1234_5678; dp_result_exc = 1'b0; dp_result_cause = '0;

        // mul then add: add delayed one cycle by writeback collision
        cycle(); issue(3'd3, 6'd20, 2'd1);
        cycle(); issue(3'd4, 6'd21, 2'd0);
        @(negedge clk); chk("t2_mul_start", 64'(dp_start), 64'(1)); chk("t2_mul_class", 64'(dp_opclass), 64'(1));
        cycle(); idle();
        @(negedge clk); chk("t2_add_blocked", 64'(dp_start), 64'(0));
        cycle();
        @(negedge clk); chk("t2_add_start", 64'(dp_start), 64'(1)); chk("t2_add_class", 64'(dp_opclass), 64'(0));
        cycle();
        @(negedge clk); chk("t2_k4_idle", 64'(fu_valid), 64'(0));
        cycle();
        @(negedge clk); chk("t2_mul_wb", 64'(fu_valid), 64'(1)); chk("t2_mul_ticket", 64'(fu_ticket), 64'(3));
        cycle();
        @(negedge clk); chk("t2_add_wb", 64'(fu_valid), 64'(1)); chk("t2_add_ticket", 64'(fu_ticket), 64'(4));
        chk("t2_add_data", 64'(fu_data), 64'h12345678);
        cycle();
        @(negedge clk); chk("t2_k7_idle", 64'(fu_valid), 64'(0));

        // two divs 12 cycles apart, add waits behind the second
        cycle(); issue(3'd5, 6'd30, 2'd2);
        cycle(); issue(3'd6, 6'd31, 2'd2);
        @(negedge clk); chk("t3_div1_start", 64'(dp_start), 64'(1)); chk("t3_div1_class", 64'(dp_opclass), 64'(2));
        cycle(); issue(3'd7, 6'd32, 2'd0);
        @(negedge clk); chk("t3_c2_stall", 64'(dp_start), 64'(0));
        cycle(); idle();
        bad = 1'b0;
        @(negedge clk); bad = bad | dp_start;
        for (int i = 4; i <= 12; i++) begin
            cycle();
            @(negedge clk); bad = bad | dp_start;
        end
        chk("t3_div_gap", 64'(bad), 64'(0));
        cycle();
        @(negedge clk);
        chk("t3_div2_start", 64'(dp_start), 64'(1)); chk("t3_div2_class", 64'(dp_opclass), 64'(2));
        chk("t3_div1_wb", 64'(fu_valid), 64'(1)); chk("t3_div1_ticket", 64'(fu_ticket), 64'(5));
        cycle();
        @(negedge clk); chk("t3_add_start", 64'(dp_start), 64'(1)); chk("t3_add_class", 64'(dp_opclass), 64'(0));
        cycle(); cycle(); cycle();
        @(negedge clk); chk("t3_add_wb", 64'(fu_ticket), 64'(7)); chk("t3_add_wb_dest", 64'(fu_destination), 64'(32));
        for (int i = 18; i <= 25; i++) cycle();
        @(negedge clk); chk("t3_div2_wb", 64'(fu_valid), 64'(1)); chk("t3_div2_ticket", 64'(fu_ticket), 64'(6));
        cycle(); cycle();

        // queue fill behind a running div: fifth valid dropped
        issue(3'd0, 6'd1, 2'd2);
        cycle(); issue(3'd1, 6'd2, 2'd2);
        @(negedge clk); chk("t4_divA_start", 64'(dp_start), 64'(1));
        cycle(); issue(3'd2, 6'd3, 2'd2);
        cycle(); issue(3'd3, 6'd4, 2'd2);
        cycle(); issue(3'd4, 6'd5, 2'd2);
        @(negedge clk); chk("t4_not_full", 64'(busy_fu), 64'(0));
        cycle(); issue(3'd5, 6'd6, 2'd2);
        @(negedge clk); chk("t4_full", 64'(busy_fu), 64'(1));
        cycle(); idle();
        @(negedge clk); chk("t4_full_hold", 64'(busy_fu), 64'(1));
        for (int i = 7; i <= 13; i++) cycle();
        @(negedge clk); chk("t4_divB_start", 64'(dp_start), 64'(1)); chk("t4_busy_c13", 64'(busy_fu), 64'(1));
        cycle();
        @(negedge clk); chk("t4_drain", 64'(busy_fu), 64'(0));
        n_disp = 0;
        last_ticket = '0;
        for (int i = 15; i <= 62; i++) begin
            cycle();
            @(negedge clk);
            if (dp_start) n_disp++;
            if (fu_valid) last_ticket = fu_ticket;
        end
        chk("t4_remaining_disp", 64'(n_disp), 64'(3));
        chk("t4_last_ticket", 64'(last_ticket), 64'(4));

        // flush with div and add in flight
        cycle(); issue(3'd1, 6'd40, 2'd2);
        cycle(); issue(3'd2, 6'd41, 2'd0);
        cycle(); issue(3'd3, 6'd42, 2'd2);
        @(negedge clk); chk("t5_add_start", 64'(dp_start), 64'(1));
        cycle(); flush = 1'b1; issue(3'd4, 6'd43, 2'd2);
        @(negedge clk); chk("t5_flush_nostart", 64'(dp_start), 64'(0));
        cycle(); flush = 1'b0; issue(3'd5, 6'd44, 2'd2);
        @(negedge clk);
        chk("t5_busy_clear", 64'(busy_fu), 64'(0));
        chk("t5_c4_start", 64'(dp_start), 64'(0));
        chk("t5_c4_valid", 64'(fu_valid), 64'(0));
        cycle(); idle();
        @(negedge clk);
        chk("t5_new_div_start", 64'(dp_start), 64'(1));
        chk("t5_add_squashed", 64'(fu_valid), 64'(0));
        bad = 1'b0;
        for (int i = 6; i <= 16; i++) begin
            cycle();
            @(negedge clk); bad = bad | fu_valid | dp_start;
        end
        chk("t5_quiet", 64'(bad), 64'(0));
        cycle();
        @(negedge clk); chk("t5_new_div_wb", 64'(fu_valid), 64'(1)); chk("t5_new_div_ticket", 64'(fu_ticket), 64'(5));
        cycle();

        // asynchronous reset mid-div
        issue(3'd1, 6'd50, 2'd2);
        cycle(); issue(3'd2, 6'd51, 2'd0);
        cycle(); issue(3'd3, 6'd52, 2'd2);
        cycle(); idle();
        cycle(); cycle();
        chk("t6_pre_rst_valid", 64'(fu_valid), 64'(1));
        chk("t6_pre_rst_busy", 64'(busy_fu), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(fu_valid), 64'(0));
        chk("t6_rst_ticket", 64'(fu_ticket), 64'(0));
        chk("t6_rst_data", 64'(fu_data), 64'(0));
        chk("t6_rst_start", 64'(dp_start), 64'(0));
        cycle();
        rst_n = 1'b1;
        issue(3'd6, 6'd53, 2'd2);
        @(negedge clk); chk("t6_r0_start", 64'(dp_start), 64'(0));
        cycle(); idle();
        @(negedge clk); chk("t6_r1_start", 64'(dp_start), 64'(1)); chk("t6_r1_class", 64'(dp_opclass), 64'(2));
        bad = 1'b0;
        for (int i = 2; i <= 12; i++) begin
            cycle();
            @(negedge clk); bad = bad | fu_valid | dp_start;
        end
        chk("t6_no_stale", 64'(bad), 64'(0));
        cycle();
        @(negedge clk); chk("t6_wb", 64'(fu_valid), 64'(1)); chk("t6_wb_ticket", 64'(fu_ticket), 64'(6));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
